// File: rtl/pwm_fade_sequencer_if.sv
// Command channel into the LED PWM sequencer: mode/channel/duty with valid-ready handshake.
// Latency: none, wires only.
// Backpressure: the sequencer drives cmd_ready; the source holds a command until it is taken.
interface pwm_fade_sequencer_if #(
  parameter int DW = 7
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_mode;
  logic [1:0]    cmd_ch;
  logic [DW-1:0] cmd_duty;

  modport master (
    output cmd_valid,
    output cmd_mode,
    output cmd_ch,
    output cmd_duty,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_mode,
    input  cmd_ch,
    input  cmd_duty,
    output cmd_ready
  );
endinterface

// File: rtl/pwm_fade_sequencer.sv
// Multi-channel LED PWM with a set/fade/breathe command sequencer and frame-aligned duty updates.
// Latency: a new duty takes effect at the next frame boundary; leds are registered one cycle behind the counter.
// Backpressure: cmd_ready drops only while a FADE is in progress; an offered command waits until accepted.
module pwm_fade_sequencer #(
  parameter int NCH         = 4,
  parameter int PERIOD      = 100,
  parameter int DW          = 7,
  parameter int STEP_FRAMES = 4
) (
  input  logic                clk,
  input  logic                rst,
  pwm_fade_sequencer_if.slave cmd,
  output logic [NCH-1:0]      leds,
  output logic                frame_tick,
  output logic                busy
);

  typedef logic [DW-1:0] duty_t;
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FADE    = 2'd1,
    ST_BREATHE = 2'd2
  } state_t;

  // Mode 3 (ALL_OFF) is handled as the default branch of the command decode.
  localparam logic [1:0] MODE_SET     = 2'd0;
  localparam logic [1:0] MODE_FADE    = 2'd1;
  localparam logic [1:0] MODE_BREATHE = 2'd2;

  localparam duty_t DUTY_MAX = duty_t'(PERIOD);
  localparam duty_t CNT_LAST = duty_t'(PERIOD - 1);
  localparam int    DIVW     = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;
  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(STEP_FRAMES - 1);

  // Frame counter
  duty_t cnt;
  duty_t cnt_nxt;
  logic  cnt_wrap;

  // Duty storage: shadow is written by commands, active is what the comparator uses
  duty_t shadow [NCH];
  duty_t active [NCH];

  // Sequencer state
  state_t          state;
  logic            ready_q;
  logic [1:0]      fade_ch;
  duty_t           fade_tgt;
  duty_t           fade_nxt;
  logic [DIVW-1:0] div;
  duty_t           breath;
  duty_t           breath_nxt;
  logic            breath_up;

  logic  accept;
  logic  ch_ok;
  logic  step_due;
  duty_t cmd_duty_c;

  // Anything beyond a full frame already reads as "always on", so store at most PERIOD.
  function automatic duty_t clamp_duty(input duty_t d);
    return (d > DUTY_MAX) ? DUTY_MAX : d;
  endfunction

  assign cnt_wrap   = (cnt == CNT_LAST);
  assign cnt_nxt    = cnt_wrap ? '0 : cnt + duty_t'(1);
  assign accept     = cmd.cmd_valid && ready_q;
  assign ch_ok      = (int'(cmd.cmd_ch) < NCH);
  assign cmd_duty_c = clamp_duty(cmd.cmd_duty);
  assign step_due   = frame_tick && (div == DIV_LAST);

  // The fade only runs while shadow differs from target, so one LSB toward it never overshoots.
  assign fade_nxt   = (shadow[fade_ch] < fade_tgt) ? shadow[fade_ch] + duty_t'(1)
                                                   : shadow[fade_ch] - duty_t'(1);
  assign breath_nxt = breath_up ? breath + duty_t'(1) : breath - duty_t'(1);

  assign cmd.cmd_ready = ready_q;

  // Free-running frame counter; frame_tick is registered so it is high exactly while cnt is on its last value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      frame_tick <= 1'b0;
    end else begin
      cnt        <= cnt_nxt;
      frame_tick <= (cnt_nxt == CNT_LAST);
    end
  end

  // Shadow-to-active transfer only at the wrap, so a frame never mixes two duty values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        active[i] <= '0;
        leds[i]   <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (cnt_wrap) begin
          active[i] <= shadow[i];
        end
        leds[i] <= (cnt < active[i]);
      end
    end
  end

  // Command decode and fade/breathe stepping; an accepted command always pre-empts a pending step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      ready_q   <= 1'b1;
      fade_ch   <= '0;
      fade_tgt  <= '0;
      div       <= '0;
      breath    <= '0;
      breath_up <= 1'b1;
      for (int i = 0; i < NCH; i++) begin
        shadow[i] <= '0;
      end
    end else if (accept) begin
      div <= '0;
      case (cmd.cmd_mode)
        MODE_SET: begin
          if (ch_ok) begin
            shadow[cmd.cmd_ch] <= cmd_duty_c;
          end
          state   <= ST_IDLE;
          busy    <= 1'b0;
          ready_q <= 1'b1;
        end
        MODE_FADE: begin
          fade_ch  <= cmd.cmd_ch;
          fade_tgt <= cmd_duty_c;
          if (ch_ok && (cmd_duty_c != shadow[cmd.cmd_ch])) begin
            state   <= ST_FADE;
            busy    <= 1'b1;
            ready_q <= 1'b0;
          end else begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        MODE_BREATHE: begin
          for (int i = 0; i < NCH; i++) begin
            shadow[i] <= '0;
          end
          breath    <= '0;
          breath_up <= 1'b1;
          state     <= ST_BREATHE;
          busy      <= 1'b1;
          ready_q   <= 1'b1;
        end
        default: begin
          for (int i = 0; i < NCH; i++) begin
            shadow[i] <= '0;
          end
          state   <= ST_IDLE;
          busy    <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end else if (frame_tick && (state != ST_IDLE)) begin
      if (!step_due) begin
        div <= div + DIVW'(1);
      end else begin
        div <= '0;
        if (state == ST_FADE) begin
          shadow[fade_ch] <= fade_nxt;
          if (fade_nxt == fade_tgt) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            ready_q <= 1'b1;
          end
        end else begin
          breath <= breath_nxt;
          for (int i = 0; i < NCH; i++) begin
            shadow[i] <= breath_nxt;
          end
          if (breath_up && (breath_nxt == DUTY_MAX)) begin
            breath_up <= 1'b0;
          end else if (!breath_up && (breath_nxt == '0)) begin
            breath_up <= 1'b1;
          end
        end
      end
    end
  end

endmodule
